program_sequencer: RTL
======================

// Module: program_sequencer
// PURPOSE
//  Fetch/decode/issue controller for the 3-bit-computer execute datapath. Holds the loaded program
//  (3-bit opcode/operand pairs), decodes each pair into execute select/write-enable controls, pulses
//  exec_en once per instruction and tracks the returned instr_ptr/halt. Buffers program output
//  digits in a small FIFO with a valid/ready handshake to the host.
// PARAMETERS
//  PROG_DEPTH   16  program memory entries (3 bit each), max program length
//  OFIFO_DEPTH  4   output digit FIFO entries (power of 2, >=2)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous active-high reset
//  load_valid     in   1   program word strobe; accepted when load_valid & load_ready
//  load_data      in   3   program word, written in order at wr_ptr
//  load_ready     out  1   1 only in IDLE and wr_ptr < PROG_DEPTH
//  start          in   1   one-cycle pulse; begins execution at ip 0
//  busy           out  1   1 in FETCH/ISSUE/WAIT
//  done           out  1   1 in DONE
//  err            out  1   sticky until next start/rst; bad length or combo operand 7
//  exec_en        out  1   one-cycle issue strobe to execute stage
//  operand_id_reg out  3   operand of issued instruction
//  op1_sel        out  2   0 COMBO, 1 LIT, 2 REG_B, 3 REG_C
//  op2_sel        out  2   same encoding
//  operation_sel  out  2   0 SHIFT, 1 XOR, 2 MOD, 3 none
//  reg_wr_en      out  5   bit0 A, bit1 B, bit2 C, bit3 OUT, bit4 jump
//  ip_in          in   4   instr_ptr from execute
//  halt_in        in   1   halt from execute
//  out_valid_in   in   1   execute produced an output digit
//  out_in         in   3   that digit
//  out_data       out  3   FIFO head
//  out_vld        out  1   FIFO non-empty
//  out_rdy        in   1   host pop; pop when out_vld & out_rdy
// BEHAVIOUR
//  Reset: state IDLE, wr_ptr/prog_len/FIFO ptrs 0, all outputs 0 except load_ready=1. Memory not cleared.
//  IDLE: load word -> mem[wr_ptr], wr_ptr++, prog_len=wr_ptr+1. start: if prog_len even and >=2 ->
//   FETCH, clear err and FIFO; else err=1, stay IDLE. Load ignored outside IDLE. A new load after
//   DONE (return to IDLE on start or rst) restarts at wr_ptr 0 only after rst.
//  FETCH (1 cycle): if ip_in >= prog_len or halt_in -> DONE; else register opcode=mem[ip_in],
//   operand=mem[ip_in+1] -> ISSUE.
//  ISSUE: waits while FIFO full (out_vld count == OFIFO_DEPTH). Then decode, exec_en=1 for exactly
//   one cycle; controls valid only while exec_en=1, otherwise reg_wr_en=0. Operand 7 used as combo
//   (opcodes 0,2,5,6,7) -> err=1, no exec_en, -> DONE.
//  Decode: 0 adv SHIFT wr=A; 1 bxl B^LIT wr=B; 2 bst MOD(COMBO) wr=B; 3 jnz none wr=jump;
//   4 bxc B^C wr=B; 5 out MOD(COMBO) wr=OUT; 6 bdv SHIFT wr=B; 7 cdv SHIFT wr=C.
//  WAIT (1 cycle after exec_en): push out_in if out_valid_in; -> FETCH. Issue-to-issue = 3 cycles.
//  FIFO: simultaneous push and pop in same cycle both occur, count unchanged; pop on empty ignored.
//   Ptrs wrap modulo OFIFO_DEPTH. Stall in ISSUE guarantees no push when full.
//  DONE: done=1; exec_en=0; FIFO keeps draining. start in DONE -> same as start in IDLE.
//  rst in any state -> IDLE next cycle, FIFO contents discarded, no exec_en.
// CONFIGURATION
//  SEQ_STEP_EN defined: extra inputs step_mode(1), step(1); with step_mode=1 ISSUE additionally
//   waits for a step pulse per instruction (one instruction per pulse; pulse outside ISSUE dropped).
//  Undefined: ports absent, ISSUE never waits on step.
// TESTING
//  Load 0,1,5,4,3,0, A=729, start, drain -> out 4,6,3,5,6,3,5,2,1,0, done=1, err=0.
//  Load 3 words then start -> err=1, busy=0, no exec_en.
//  Load 2,7 then start -> err=1, DONE, exec_en never asserted.
//  out_rdy=0 with 5,4,5,4,5,4,5,4,5,4 -> 4 digits buffered, 5th out stalls in ISSUE until one pop.
//  Assert rst during WAIT -> next cycle IDLE, out_vld=0, load_ready=1, exec_en=0.
//  SEQ_STEP_EN, step_mode=1: 3 step pulses -> exactly 3 exec_en pulses.

Source files
------------

// File: rtl/program_sequencer_if.sv
// rtl/program_sequencer_if.sv - host-side program load stream and output digit stream
// slave: sequencer side; master: host side.
interface program_sequencer_if;
   logic       load_valid;
   logic [2:0] load_data;
   logic       load_ready;
   logic [2:0] out_data;
   logic       out_vld;
   logic       out_rdy;

   modport slave (
      input  load_valid,
      input  load_data,
      input  out_rdy,
      output load_ready,
      output out_data,
      output out_vld
   );

   modport master (
      output load_valid,
      output load_data,
      output out_rdy,
      input  load_ready,
      input  out_data,
      input  out_vld
   );
endinterface

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - fetch/decode/issue controller for the 3-bit-computer execute stage
// Optional single-step issue gating is compiled in when SEQ_STEP_EN is defined.
module program_sequencer #(
   parameter int PROG_DEPTH  = 16,
   parameter int OFIFO_DEPTH = 4
) (
   input  logic               clk,
   input  logic               rst,
   program_sequencer_if.slave host,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_done,
   output logic               o_err,
   output logic               o_exec_en,
   output logic [2:0]         o_operand_id_reg,
   output logic [1:0]         o_op1_sel,
   output logic [1:0]         o_op2_sel,
   output logic [1:0]         o_operation_sel,
   output logic [4:0]         o_reg_wr_en,
   input  logic [3:0]         i_ip_in,
   input  logic               i_halt_in,
   input  logic               i_out_valid_in,
   input  logic [2:0]         i_out_in
`ifdef SEQ_STEP_EN
   ,
   input  logic               i_step_mode,
   input  logic               i_step
`endif
);

   localparam int PW = $clog2(PROG_DEPTH + 1);
   localparam int AW = $clog2(PROG_DEPTH);
   localparam int FW = $clog2(OFIFO_DEPTH);
   localparam int CW = FW + 1;

   localparam logic [PW-1:0] LEN_MAX   = PW'(PROG_DEPTH);
   localparam logic [CW-1:0] FIFO_FULL = CW'(OFIFO_DEPTH);

   localparam logic [1:0] SEL_COMBO = 2'd0;
   localparam logic [1:0] SEL_LIT   = 2'd1;
   localparam logic [1:0] SEL_REG_B = 2'd2;
   localparam logic [1:0] SEL_REG_C = 2'd3;

   localparam logic [1:0] OP_SHIFT = 2'd0;
   localparam logic [1:0] OP_XOR   = 2'd1;
   localparam logic [1:0] OP_MOD   = 2'd2;
   localparam logic [1:0] OP_NONE  = 2'd3;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_ISSUE = 3'd2,
      S_WAIT  = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   state_t          r_state;
   state_t          w_next_state;

   logic [2:0]      r_mem [PROG_DEPTH];
   logic [PW-1:0]   r_wr_ptr;
   logic [PW-1:0]   r_prog_len;
   logic            r_err;
   logic [2:0]      r_opcode;
   logic [2:0]      r_operand;

   logic [2:0]      r_fifo [OFIFO_DEPTH];
   logic [FW-1:0]   r_fifo_wr;
   logic [FW-1:0]   r_fifo_rd;
   logic [CW-1:0]   r_fifo_cnt;

   logic            w_load_ready;
   logic            w_load;
   logic            w_len_ok;
   logic            w_uses_combo;
   logic            w_combo_bad;
   logic            w_fifo_full;
   logic            w_out_vld;
   logic            w_step_ok;
   logic            w_exec_en;
   logic            w_set_err;
   logic            w_clr_err;
   logic            w_fifo_clr;
   logic            w_fetch;
   logic            w_push;
   logic            w_pop;
   logic [PW-1:0]   w_ip_ext;
   logic [3:0]      w_ip_next;

   assign w_load_ready = (r_state == S_IDLE) && (r_wr_ptr < LEN_MAX);
   assign w_load       = host.load_valid && w_load_ready;
   assign w_len_ok     = (r_prog_len[0] == 1'b0) && (r_prog_len >= PW'(2));
   assign w_uses_combo = (r_opcode == 3'd0) || (r_opcode == 3'd2) || (r_opcode == 3'd5) ||
                         (r_opcode == 3'd6) || (r_opcode == 3'd7);
   assign w_combo_bad  = w_uses_combo && (r_operand == 3'd7);
   assign w_fifo_full  = (r_fifo_cnt == FIFO_FULL);
   assign w_out_vld    = (r_fifo_cnt != '0);
   assign w_ip_ext     = PW'(i_ip_in);
   assign w_ip_next    = i_ip_in + 4'd1;

`ifdef SEQ_STEP_EN
   // A step pulse only matters while an instruction is held in ISSUE.
   assign w_step_ok = ~i_step_mode | i_step;
`else
   assign w_step_ok = 1'b1;
`endif

   assign w_push = (r_state == S_WAIT) && i_out_valid_in;
   assign w_pop  = w_out_vld && host.out_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   always_comb begin
      w_next_state = r_state;
      w_exec_en    = 1'b0;
      w_set_err    = 1'b0;
      w_clr_err    = 1'b0;
      w_fifo_clr   = 1'b0;
      w_fetch      = 1'b0;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (i_start) begin
               if (w_len_ok) begin
                  w_next_state = S_FETCH;
                  w_clr_err    = 1'b1;
                  w_fifo_clr   = 1'b1;
               end else begin
                  w_next_state = S_IDLE;
                  w_set_err    = 1'b1;
               end
            end
         end
         S_FETCH: begin
            if ((w_ip_ext >= r_prog_len) || i_halt_in) begin
               w_next_state = S_DONE;
            end else begin
               w_fetch      = 1'b1;
               w_next_state = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // Holding here while the FIFO is full means WAIT can never push into a full FIFO.
            if (!w_fifo_full && w_step_ok) begin
               if (w_combo_bad) begin
                  w_set_err    = 1'b1;
                  w_next_state = S_DONE;
               end else begin
                  w_exec_en    = 1'b1;
                  w_next_state = S_WAIT;
               end
            end
         end
         S_WAIT: begin
            w_next_state = S_FETCH;
         end
         default: begin
            w_next_state = S_IDLE;
         end
      endcase
   end

   always_comb begin
      o_op1_sel       = SEL_COMBO;
      o_op2_sel       = SEL_COMBO;
      o_operation_sel = OP_SHIFT;
      o_reg_wr_en     = 5'b00000;
      if (w_exec_en) begin
         case (r_opcode)
            3'd0: begin
               o_op1_sel       = SEL_COMBO;
               o_operation_sel = OP_SHIFT;
               o_reg_wr_en     = 5'b00001;
            end
            3'd1: begin
               o_op1_sel       = SEL_REG_B;
               o_op2_sel       = SEL_LIT;
               o_operation_sel = OP_XOR;
               o_reg_wr_en     = 5'b00010;
            end
            3'd2: begin
               o_op1_sel       = SEL_COMBO;
               o_operation_sel = OP_MOD;
               o_reg_wr_en     = 5'b00010;
            end
            3'd3: begin
               o_operation_sel = OP_NONE;
               o_reg_wr_en     = 5'b10000;
            end
            3'd4: begin
               o_op1_sel       = SEL_REG_B;
               o_op2_sel       = SEL_REG_C;
               o_operation_sel = OP_XOR;
               o_reg_wr_en     = 5'b00010;
            end
            3'd5: begin
               o_op1_sel       = SEL_COMBO;
               o_operation_sel = OP_MOD;
               o_reg_wr_en     = 5'b01000;
            end
            3'd6: begin
               o_op1_sel       = SEL_COMBO;
               o_operation_sel = OP_SHIFT;
               o_reg_wr_en     = 5'b00010;
            end
            default: begin
               o_op1_sel       = SEL_COMBO;
               o_operation_sel = OP_SHIFT;
               o_reg_wr_en     = 5'b00100;
            end
         endcase
      end
   end

   // Program memory keeps its contents across reset; only the pointers are cleared.
   always_ff @(posedge clk) begin
      if (w_load) begin
         r_mem[r_wr_ptr[AW-1:0]] <= host.load_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr   <= '0;
         r_prog_len <= '0;
         r_err      <= 1'b0;
         r_opcode   <= 3'd0;
         r_operand  <= 3'd0;
      end else begin
         if (w_load) begin
            r_wr_ptr   <= r_wr_ptr + PW'(1);
            r_prog_len <= r_wr_ptr + PW'(1);
         end
         if (w_set_err) begin
            r_err <= 1'b1;
         end else if (w_clr_err) begin
            r_err <= 1'b0;
         end
         if (w_fetch) begin
            r_opcode  <= r_mem[AW'(i_ip_in)];
            r_operand <= r_mem[AW'(w_ip_next)];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_fifo[r_fifo_wr] <= i_out_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || w_fifo_clr) begin
         r_fifo_wr  <= '0;
         r_fifo_rd  <= '0;
         r_fifo_cnt <= '0;
      end else begin
         if (w_push) begin
            r_fifo_wr <= r_fifo_wr + FW'(1);
         end
         if (w_pop) begin
            r_fifo_rd <= r_fifo_rd + FW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_fifo_cnt <= r_fifo_cnt + CW'(1);
            2'b01:   r_fifo_cnt <= r_fifo_cnt - CW'(1);
            default: r_fifo_cnt <= r_fifo_cnt;
         endcase
      end
   end

   assign host.load_ready = w_load_ready;
   assign host.out_vld    = w_out_vld;
   assign host.out_data   = w_out_vld ? r_fifo[r_fifo_rd] : 3'd0;

   assign o_busy           = (r_state == S_FETCH) || (r_state == S_ISSUE) || (r_state == S_WAIT);
   assign o_done           = (r_state == S_DONE);
   assign o_err            = r_err;
   assign o_exec_en        = w_exec_en;
   assign o_operand_id_reg = r_operand;

endmodule
